// File: rtl/instr_stream_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus
// shared by the program loader and its producer.
interface instr_stream_encoder_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        opcode;
  logic [3:0]        rd;
  logic [3:0]        rs;
  logic [3:0]        rt;
  logic [11:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    output in_valid, opcode, rd, rs, rt, imm,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, opcode, rd, rs, rt, imm,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_stream_encoder.sv
// Boot/program loader: packs instruction fields into 16-bit words
// and writes them to instruction memory at consecutive addresses.
module instr_stream_encoder #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W-1:0] base_addr,
  instr_stream_encoder_if.slave bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              done,
  output logic              err
);

  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_STR  = 4'hB;
  localparam logic [3:0] OP_BEQ  = 4'hC;
  localparam logic [3:0] OP_B    = 4'hD;
  localparam logic [3:0] OP_BL   = 4'hE;
  localparam logic [3:0] OP_BR   = 4'hF;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_FULL   = 2'd3;

  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       wdata_q;
  logic              start_pend;
  logic [ADDR_W-1:0] pend_base;

  logic [3:0]  op;
  logic [15:0] word;
  logic        legal;
  logic        is_r, is_not, is_iu, is_beq, is_j, is_br;
  logic [ADDR_W:0] cnt_nx;

  assign bus.in_ready  = (state == S_ACCEPT);
  assign bus.mem_we    = (state == S_WRITE);
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign full          = (state == S_FULL);
  assign cnt_nx        = count + 1'b1;

  always_comb begin
    op     = bus.opcode;
    is_r   = (op <= OP_SLT);
    is_not = (op == OP_NOT);
    is_iu  = (op >= OP_ADDI) && (op <= OP_STR);
    is_beq = (op == OP_BEQ);
    is_j   = (op == OP_B) || (op == OP_BL);
    is_br  = (op == OP_BR);
    word   = '0;
    legal  = 1'b1;
    unique case (1'b1)
      is_r:   word = {op, bus.rd, bus.rs, bus.rt};
      is_not: word = {op, bus.rd, bus.rs, 4'h0};
      is_iu: begin
        word  = {op, bus.rd, bus.rs, bus.imm[3:0]};
        legal = (bus.imm[11:4] == 8'h00);
      end
      is_beq: begin
        word  = {op, bus.rs, bus.rt, bus.imm[3:0]};
        // -8..7: the upper nine bits must be pure sign extension
        legal = (&bus.imm[11:3]) | ~(|bus.imm[11:3]);
      end
      is_j:   word = {op, bus.imm};
      is_br:  word = {op, bus.rs, 8'h00};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      count      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      start_pend <= 1'b0;
      pend_base  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ACCEPT;
            addr_q <= base_addr;
            count  <= '0;
            err    <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (bus.in_valid && legal) begin
            wdata_q <= word;
            state   <= S_WRITE;
            if (start) begin
              start_pend <= 1'b1;
              pend_base  <= base_addr;
            end
          end else if (start) begin
            addr_q <= base_addr;
            count  <= '0;
            err    <= 1'b0;
          end else if (bus.in_valid) begin
            err <= 1'b1;
          end else if (stop) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
        S_WRITE: begin
          start_pend <= 1'b0;
          if (start || start_pend) begin
            state  <= S_ACCEPT;
            addr_q <= start ? base_addr : pend_base;
            count  <= '0;
            err    <= 1'b0;
          end else begin
            count <= cnt_nx;
            if (addr_q != ADDR_MAX)
              addr_q <= addr_q + 1'b1;
            if (cnt_nx == DEPTH_C || addr_q == ADDR_MAX)
              state <= S_FULL;
            else
              state <= S_ACCEPT;
          end
        end
        default: begin
          if (start) begin
            state  <= S_ACCEPT;
            addr_q <= base_addr;
            count  <= '0;
            err    <= 1'b0;
          end else if (stop) begin
            state <= S_IDLE;
            done  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/instr_stream_encoder.md
Name: instr_stream_encoder

Overview:
- Sequential instruction encoder and writer: the producer-side counterpart of the control decoder.
- Accepts assembled instruction fields over a valid/ready handshake, packs them into 16-bit instruction words using the opcode macros from macro_defines.v, range-checks immediates, and writes the words into instruction memory at consecutive addresses.
- Used as the boot/program loader ahead of the 16-bit CPU core.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must be ≤ 2**ADDR_W.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  pulse; loads base_addr, clears count, begins a load session
- stop  input  1  pulse; ends the session
- base_addr  input  ADDR_W  first write address, sampled on start
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- opcode  input  4  instruction opcode (macro_defines.v values)
- rd  input  4  destination register
- rs  input  4  source register 1
- rt  input  4  source register 2
- imm  input  12  immediate, two's complement
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  16  encoded instruction word
- count  output  ADDR_W+1  words written this session
- full  output  1  DEPTH words written or address space end reached
- done  output  1  one-cycle pulse when a session ends via stop
- err  output  1  sticky immediate-range error, cleared by start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset values: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, count=0, full=0, done=0, err=0.
- Encoding: word[15:12]=opcode.
  - R-format (add, sub, and, or, xor, slt): [11:8]=rd, [7:4]=rs, [3:0]=rt.
  - not: rd, rs, [3:0]=0.
  - I-format unsigned (addi, lsl, lsr, ldr, str): [11:8]=rd, [7:4]=rs, [3:0]=imm[3:0]. Legal only when imm[11:4]==0.
  - beq: [11:8]=rs, [7:4]=rt, [3:0]=imm[3:0]. Legal only when imm[11:3] are all equal (range −8..7).
  - b, bl: [11:0]=imm; always legal.
  - br: [11:8]=rs, [7:0]=0.
- States:
  - IDLE: in_ready=0. start → ACCEPT with mem_addr←base_addr, count←0, err←0, full←0.
  - ACCEPT: in_ready=1.
    - in_valid&&in_ready with a legal bundle: latch word into mem_wdata → WRITE.
    - Illegal bundle: consumed, nothing written, err←1, stay in ACCEPT.
    - stop with no handshake in the same cycle → IDLE, done=1 for one cycle.
    - stop together with a handshake: the handshake completes first; stop is ignored.
  - WRITE: in_ready=0, mem_we=1 for exactly one cycle at the current mem_addr/mem_wdata. On the next edge count+1 and mem_addr+1.
    - If count+1==DEPTH or mem_addr==2**ADDR_W−1 → FULL (mem_addr holds, no wrap).
    - Otherwise → ACCEPT.
  - FULL: full=1, in_ready=0, further bundles are not accepted. start → ACCEPT (new session). stop → IDLE with done pulse.
- Latency and throughput: accept at edge N, mem_we asserted during cycle N+1. Throughput is one word per 2 cycles.
- start while in ACCEPT or WRITE: the in-flight WRITE still completes its write, then the new session is loaded. start in ACCEPT restarts immediately.
- Reset mid-WRITE: mem_we drops on the reset edge; the word is lost.
- mem_wdata holds its last value outside WRITE; mem_we is the only qualifier.

Test Plan:
- Reset, start with base_addr=0x10, send add rd=1 rs=2 rt=3 → in_ready drops for one cycle; mem_we=1 at addr 0x10 with wdata={`add,4'h1,4'h2,4'h3}; count=1.
- Send addi rd=4 rs=0 imm=0x00F, then lsl rd=5 rs=5 imm=0x010 → first is written as {`addi,4'h4,4'h0,4'hF}. Second sets err=1, produces no mem_we, and count stays unchanged.
- Send beq rs=1 rt=2 imm=0xFF8 (−8), then imm=0x008 → first is written with [3:0]=4'h8. Second sets err.
- Send b imm=0xABC and br rs=7 → words {`b,12'hABC} and {`br,4'h7,8'h00}.
- DEPTH=4, start base=0, stream 6 bundles back-to-back → exactly 4 writes at addr 0..3, full=1, in_ready=0 thereafter. stop → done pulse, state IDLE.
- Assert rst_n=0 during the WRITE cycle → mem_we=0 next cycle, all outputs at reset values. Then start with stop in the same cycle as a handshake → the bundle is written and the session continues.
